// File: rtl/count_pwm_gen_pkg.sv
// Shared constants and FSM encoding for the count-driven PWM generator.
// Used by the RTL and its testbench.
package count_pwm_gen_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefPcntW = 8;

  typedef enum logic {
    StSync = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/wrap_detect.sv
// Registers the upstream count and flags a wrap (return to zero from any nonzero value).
// count_q resets to 0 so a count held at 0 never looks like a wrap.
module wrap_detect #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] r_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count_q <= '0;
    end else begin
      r_count_q <= count;
    end
  end

  assign wrap = (count == '0) && (r_count_q != '0);

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator slaved to an upstream free-running counter; duty updates take
// effect only at counter wraps so a period is never glitched.
module count_pwm_gen
  import count_pwm_gen_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned PCNT_W = DefPcntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count,
  input  logic [WIDTH-1:0]  duty_in,
  input  logic              duty_wr,
  output logic              pwm_out,
  output logic              wrap_pulse,
  output logic [WIDTH-1:0]  duty_active,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              synced
);

  localparam logic [PCNT_W-1:0] PcntMax = '1;

  logic              w_wrap;
  state_e            r_state;
  state_e            w_state_next;
  logic              w_pwm_en;
  logic              w_synced;

  logic [WIDTH-1:0]  r_duty_active;
  logic [WIDTH-1:0]  w_duty_next;
  logic [WIDTH-1:0]  r_duty_pend;
  logic [WIDTH-1:0]  w_duty_pend_next;
  logic              r_pend;
  logic              w_pend_next;

  logic              r_pwm;
  logic              r_wrap_pulse;
  logic [PCNT_W-1:0] r_period_cnt;

  wrap_detect #(
    .WIDTH (WIDTH)
  ) u_wrap_detect (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .wrap  (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StSync;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StSync:  if (w_wrap) w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StSync;
    endcase
  end

  // PWM is enabled from the wrap cycle itself so count 0 of the first period is covered.
  always_comb begin
    w_synced = (r_state == StRun);
    w_pwm_en = (w_state_next == StRun);
  end

  // A write coinciding with a wrap goes straight to the active duty.
  always_comb begin
    w_duty_next      = r_duty_active;
    w_duty_pend_next = r_duty_pend;
    w_pend_next      = r_pend;
    if (w_wrap) begin
      w_pend_next = 1'b0;
      if (duty_wr) begin
        w_duty_next = duty_in;
      end else if (r_pend) begin
        w_duty_next = r_duty_pend;
      end
    end else if (duty_wr) begin
      w_pend_next      = 1'b1;
      w_duty_pend_next = duty_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty_active <= '0;
      r_duty_pend   <= '0;
      r_pend        <= 1'b0;
      r_pwm         <= 1'b0;
      r_wrap_pulse  <= 1'b0;
      r_period_cnt  <= '0;
    end else begin
      r_duty_active <= w_duty_next;
      r_duty_pend   <= w_duty_pend_next;
      r_pend        <= w_pend_next;
      r_pwm         <= w_pwm_en && (count < w_duty_next);
      r_wrap_pulse  <= w_wrap;
      if (w_wrap && (r_period_cnt != PcntMax)) begin
        r_period_cnt <= r_period_cnt + 1'b1;
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign wrap_pulse  = r_wrap_pulse;
  assign duty_active = r_duty_active;
  assign period_cnt  = r_period_cnt;
  assign synced      = w_synced;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed self-checking bench for count_pwm_gen: sync, duty updates, boundaries,
// resets and period counter saturation.
module tb_count_pwm_gen;
  import count_pwm_gen_pkg::*;

  localparam int unsigned W = DefWidth;
  localparam int unsigned P = DefPcntW;

  logic         clk;
  logic         rst;
  logic [W-1:0] count;
  logic [W-1:0] duty_in;
  logic         duty_wr;
  logic         pwm_out;
  logic         wrap_pulse;
  logic [W-1:0] duty_active;
  logic [P-1:0] period_cnt;
  logic         synced;

  int n_checks = 0;
  int n_errors = 0;

  count_pwm_gen #(
    .WIDTH  (W),
    .PCNT_W (P)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .duty_in     (duty_in),
    .duty_wr     (duty_wr),
    .pwm_out     (pwm_out),
    .wrap_pulse  (wrap_pulse),
    .duty_active (duty_active),
    .period_cnt  (period_cnt),
    .synced      (synced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One 16-cycle period starting at count 0, with up to two duty writes.
  task automatic run_period(input int wr_k, input int wr_val, input int wr_k2, input int wr_val2,
                            output int highs, output int pulses, output int wrap0,
                            output int duty0, output int duty15);
    highs  = 0;
    pulses = 0;
    wrap0  = 0;
    duty0  = 0;
    duty15 = 0;
    for (int k = 0; k < 16; k++) begin
      count   = W'(k);
      duty_wr = (k == wr_k) || (k == wr_k2);
      duty_in = (k == wr_k2) ? W'(wr_val2) : W'(wr_val);
      cyc();
      highs  += int'(pwm_out);
      pulses += int'(wrap_pulse);
      if (k == 0) begin
        wrap0 = int'(wrap_pulse);
        duty0 = int'(duty_active);
      end
      if (k == 15) duty15 = int'(duty_active);
    end
    duty_wr = 1'b0;
  endtask

  initial begin
    int highs, pulses, wrap0, duty0, duty15;
    int any_pwm, any_sync;

    rst     = 1'b1;
    count   = '0;
    duty_in = '0;
    duty_wr = 1'b0;
    cyc();
    cyc();
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_wrap", 32'(wrap_pulse), 0);
    check("rst_duty", 32'(duty_active), 0);
    check("rst_pcnt", 32'(period_cnt), 0);
    check("rst_synced", 32'(synced), 0);

    // Count held at 0 after reset must not look like a wrap.
    rst = 1'b0;
    cyc();
    cyc();
    cyc();
    check("hold0_wrap", 32'(wrap_pulse), 0);
    check("hold0_synced", 32'(synced), 0);

    // Ramp 1..15 in SYNC with duty 5 queued at count 3.
    any_pwm  = 0;
    any_sync = 0;
    for (int k = 1; k < 16; k++) begin
      count   = W'(k);
      duty_wr = (k == 3);
      duty_in = 4'd5;
      cyc();
      any_pwm  += int'(pwm_out);
      any_sync += int'(synced);
    end
    duty_wr = 1'b0;
    check("sync_pwm_low", 32'(any_pwm), 0);
    check("sync_not_synced", 32'(any_sync), 0);
    check("sync_duty_pending", 32'(duty_active), 0);

    // Period 1: first wrap syncs and applies pending duty 5.
    run_period(-1, 0, -1, 0, highs, pulses, wrap0, duty0, duty15);
    check("p1_wrap_at0", 32'(wrap0), 1);
    check("p1_pulses", 32'(pulses), 1);
    check("p1_duty0", 32'(duty0), 5);
    check("p1_highs", 32'(highs), 5);
    check("p1_synced", 32'(synced), 1);
    check("p1_pcnt", 32'(period_cnt), 1);

    // Period 2: write 12 mid-period; current period keeps 5.
    run_period(7, 12, -1, 0, highs, pulses, wrap0, duty0, duty15);
    check("p2_highs", 32'(highs), 5);
    check("p2_duty15", 32'(duty15), 5);

    // Period 3: 12 in force; queue duty 0.
    run_period(7, 0, -1, 0, highs, pulses, wrap0, duty0, duty15);
    check("p3_duty0", 32'(duty0), 12);
    check("p3_highs", 32'(highs), 12);

    // Period 4: duty 0; queue duty 15.
    run_period(5, 15, -1, 0, highs, pulses, wrap0, duty0, duty15);
    check("p4_highs_duty0", 32'(highs), 0);

    // Period 5: duty 15.
    run_period(-1, 0, -1, 0, highs, pulses, wrap0, duty0, duty15);
    check("p5_highs_duty15", 32'(highs), 15);

    // Period 6: write 9 on the wrap cycle itself.
    run_period(0, 9, -1, 0, highs, pulses, wrap0, duty0, duty15);
    check("p6_bypass_duty", 32'(duty0), 9);
    check("p6_highs", 32'(highs), 9);

    // Period 7: two writes; the later one wins.
    run_period(2, 3, 10, 6, highs, pulses, wrap0, duty0, duty15);
    check("p7_highs", 32'(highs), 9);
    run_period(-1, 0, -1, 0, highs, pulses, wrap0, duty0, duty15);
    check("p8_overwrite_highs", 32'(highs), 6);
    check("p8_pcnt", 32'(period_cnt), 8);

    // Upstream counter reset at count 9.
    for (int k = 0; k < 10; k++) begin
      count = W'(k);
      cyc();
    end
    check("p9_pcnt", 32'(period_cnt), 9);
    count = '0;
    cyc();
    check("up_rst_wrap", 32'(wrap_pulse), 1);
    check("up_rst_pcnt", 32'(period_cnt), 10);
    count   = 4'd1;
    duty_wr = 1'b1;
    duty_in = 4'd11;
    cyc();
    duty_wr = 1'b0;
    check("up_rst_pulse_once", 32'(wrap_pulse), 0);

    // Local reset mid-period discards pending duty 11.
    count = 4'd2;
    rst   = 1'b1;
    cyc();
    check("mid_rst_pwm", 32'(pwm_out), 0);
    check("mid_rst_wrap", 32'(wrap_pulse), 0);
    check("mid_rst_duty", 32'(duty_active), 0);
    check("mid_rst_pcnt", 32'(period_cnt), 0);
    check("mid_rst_synced", 32'(synced), 0);
    rst      = 1'b0;
    any_sync = 0;
    for (int k = 3; k < 16; k++) begin
      count = W'(k);
      cyc();
      any_sync += int'(synced);
    end
    check("resync_wait", 32'(any_sync), 0);
    count = '0;
    cyc();
    check("resync_synced", 32'(synced), 1);
    check("resync_pcnt", 32'(period_cnt), 1);
    check("resync_pend_dropped", 32'(duty_active), 0);
    check("resync_pwm", 32'(pwm_out), 0);

    // Saturation: finish this period, then 300 more wraps in total.
    for (int k = 1; k < 16; k++) begin
      count = W'(k);
      cyc();
    end
    for (int p = 0; p < 300; p++) begin
      for (int k = 0; k < 16; k++) begin
        count = W'(k);
        cyc();
      end
      if (p == 252) check("sat_pre", 32'(period_cnt), 254);
      if (p == 253) check("sat_hit", 32'(period_cnt), 255);
    end
    check("sat_hold", 32'(period_cnt), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
